rgb_video_rx: RTL and testbench

Receiver for the parallel RGB video interface (VS/HS/DE plus 24-bit pixel bus) that the LCD output path produces. It samples an incoming RGB888 stream, converts each pixel to RGB565, and tags it with its x/y position. It also measures the active resolution, pulses at frame start and frame end, and counts frames. It sits in front of the frame-buffer write path for loopback capture and for link self-test of the LCD output.

---
 rtl/rgb_video_rx_if.sv | 26 ++
 rtl/rgb_video_rx.sv | 224 ++++++++++++++++++++++
 tb/tb_rgb_video_rx.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rgb_video_rx_if.sv
// rgb_video_rx_if: parallel RGB video link in, RGB565 pixel stream out.
// slave = receiver side, master = link source / stream consumer.
interface rgb_video_rx_if;
  logic        rx_vs;
  logic        rx_hs;
  logic        rx_de;
  logic [23:0] rx_rgb;
  logic        pix_valid;
  logic [15:0] pix_data;
  logic [10:0] pix_xpos;
  logic [10:0] pix_ypos;
  logic        frame_start;
  logic        frame_done;

  modport master (
    output rx_vs, rx_hs, rx_de, rx_rgb,
    input  pix_valid, pix_data, pix_xpos, pix_ypos,
    input  frame_start, frame_done
  );

  modport slave (
    input  rx_vs, rx_hs, rx_de, rx_rgb,
    output pix_valid, pix_data, pix_xpos, pix_ypos,
    output frame_start, frame_done
  );
endinterface

// File: rtl/rgb_video_rx.sv
// rgb_video_rx: RGB888 video capture to RGB565 with x/y tags and resolution measure.
// Optional crop window: define RGB_RX_CROP_EN.
module rgb_video_rx #(
  parameter int H_MAX    = 1024,
  parameter int V_MAX    = 768,
  parameter bit SYNC_POL = 1'b0,
  parameter int CROP_X0  = 0,
  parameter int CROP_Y0  = 0,
  parameter int CROP_W   = 800,
  parameter int CROP_H   = 480
) (
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          enable,
  rgb_video_rx_if.slave vif,
  output logic [10:0]   h_disp,
  output logic [10:0]   v_disp,
  output logic          res_valid,
  output logic [7:0]    frame_cnt,
  output logic          err_ovf
);
  typedef enum logic [1:0] {IDLE, WAIT_VS, ACTIVE} state_e;

  localparam logic [10:0] HM = 11'(H_MAX);
  localparam logic [10:0] VM = 11'(V_MAX);

  state_e      state_q, state_d;
  logic        vs_q, vs_p_q, hs_q, de_q, de_p_q;
  logic [23:0] rgb_q;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] hmax_q, hmax_d;
  logic        any_q, any_d, first_q, first_d;
  logic        pv_q, pv_d;
  logic [15:0] pd_q, pd_d;
  logic [10:0] px_q, px_d, py_q, py_d;
  logic        fs_q, fs_d, fd_q, fd_d;
  logic [10:0] hd_q, hd_d, vd_q, vd_d;
  logic        rv_q, rv_d;
  logic [7:0]  fc_q, fc_d;
  logic        err_q, err_d;

  logic        vs_edge, de_fall, pix, emit;
  logic [10:0] xc, yc, ox, oy;
  logic [10:0] y_inc, h_fin, v_fin;

  assign vs_edge = (vs_q == SYNC_POL) && (vs_p_q != SYNC_POL);
  assign de_fall = de_p_q && !de_q;
  assign pix     = (state_q == ACTIVE) && de_q;
  assign xc      = (x_q == HM) ? HM - 11'd1 : x_q;
  assign yc      = (y_q == VM) ? VM - 11'd1 : y_q;
  assign y_inc   = (y_q == VM) ? VM : y_q + 11'd1;

  // A line ending on the VS edge still belongs to the finishing frame
  always_comb begin
    h_fin = hmax_q;
    v_fin = y_q;
    if (de_fall) begin
      h_fin = (x_q > hmax_q) ? x_q : hmax_q;
      v_fin = y_inc;
    end
  end

`ifdef RGB_RX_CROP_EN
  localparam int X1 = CROP_X0 + CROP_W;
  localparam int Y1 = CROP_Y0 + CROP_H;

  always_comb begin
    emit = pix
      && (int'(xc) >= CROP_X0) && (int'(xc) < X1)
      && (int'(yc) >= CROP_Y0) && (int'(yc) < Y1);
    ox = xc - 11'(CROP_X0);
    oy = yc - 11'(CROP_Y0);
  end
`else
  assign emit = pix;
  assign ox   = xc;
  assign oy   = yc;

  logic unused_cfg;
  assign unused_cfg = ^{11'(CROP_X0), 11'(CROP_Y0),
                        11'(CROP_W), 11'(CROP_H)};
`endif

  logic unused_in;
  assign unused_in = ^{hs_q, rgb_q[18:16], rgb_q[9:8], rgb_q[2:0]};

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    hmax_d  = hmax_q;
    any_d   = any_q;
    first_d = first_q;
    pv_d    = 1'b0;
    pd_d    = pd_q;
    px_d    = px_q;
    py_d    = py_q;
    fs_d    = 1'b0;
    fd_d    = 1'b0;
    hd_d    = hd_q;
    vd_d    = vd_q;
    rv_d    = rv_q;
    fc_d    = fc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAIT_VS;
          err_d   = 1'b0;
        end
      end
      WAIT_VS: begin
        if (vs_edge) begin
          state_d = ACTIVE;
          x_d     = '0;
          y_d     = '0;
          hmax_d  = '0;
          any_d   = 1'b0;
          first_d = 1'b1;
        end
      end
      ACTIVE: begin
        if (pix) begin
          x_d   = (x_q == HM) ? HM : x_q + 11'd1;
          any_d = 1'b1;
          if (x_q == HM || y_q == VM) err_d = 1'b1;
        end
        if (emit) begin
          pv_d    = 1'b1;
          pd_d    = {rgb_q[23:19], rgb_q[15:10], rgb_q[7:3]};
          px_d    = ox;
          py_d    = oy;
          fs_d    = first_q;
          first_d = 1'b0;
        end
        if (de_fall) begin
          x_d    = '0;
          y_d    = y_inc;
          hmax_d = h_fin;
        end
        if (vs_edge) begin
          fd_d = 1'b1;
          fc_d = fc_q + 8'd1;
          if (any_q || pix) begin
            hd_d = h_fin;
            vd_d = v_fin;
            rv_d = 1'b1;
          end
          state_d = enable ? ACTIVE : IDLE;
          x_d     = '0;
          y_d     = '0;
          hmax_d  = '0;
          any_d   = 1'b0;
          first_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      vs_q    <= ~SYNC_POL;
      vs_p_q  <= ~SYNC_POL;
      hs_q    <= 1'b0;
      de_q    <= 1'b0;
      de_p_q  <= 1'b0;
      rgb_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hmax_q  <= '0;
      any_q   <= 1'b0;
      first_q <= 1'b0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      px_q    <= '0;
      py_q    <= '0;
      fs_q    <= 1'b0;
      fd_q    <= 1'b0;
      hd_q    <= '0;
      vd_q    <= '0;
      rv_q    <= 1'b0;
      fc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vif.rx_vs;
      vs_p_q  <= vs_q;
      hs_q    <= vif.rx_hs;
      de_q    <= vif.rx_de;
      de_p_q  <= de_q;
      rgb_q   <= vif.rx_rgb;
      x_q     <= x_d;
      y_q     <= y_d;
      hmax_q  <= hmax_d;
      any_q   <= any_d;
      first_q <= first_d;
      pv_q    <= pv_d;
      pd_q    <= pd_d;
      px_q    <= px_d;
      py_q    <= py_d;
      fs_q    <= fs_d;
      fd_q    <= fd_d;
      hd_q    <= hd_d;
      vd_q    <= vd_d;
      rv_q    <= rv_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
    end
  end

  assign vif.pix_valid   = pv_q;
  assign vif.pix_data    = pd_q;
  assign vif.pix_xpos    = px_q;
  assign vif.pix_ypos    = py_q;
  assign vif.frame_start = fs_q;
  assign vif.frame_done  = fd_q;
  assign h_disp          = hd_q;
  assign v_disp          = vd_q;
  assign res_valid       = rv_q;
  assign frame_cnt       = fc_q;
  assign err_ovf         = err_q;
endmodule

// File: tb/tb_rgb_video_rx.sv
// tb_rgb_video_rx: random video frames against a frame-level reference model.
// Pixels are scoreboarded; status is compared after every frame boundary.
module tb_rgb_video_rx;
  localparam int HM  = 8;
  localparam int VM  = 6;
  localparam int CX0 = 2;
  localparam int CY0 = 1;
  localparam int CW  = 4;
  localparam int CH  = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b0;
  logic [10:0] h_disp, v_disp;
  logic        res_valid;
  logic [7:0]  frame_cnt;
  logic        err_ovf;

  rgb_video_rx_if vif();

  rgb_video_rx #(
    .H_MAX(HM), .V_MAX(VM), .SYNC_POL(1'b0),
    .CROP_X0(CX0), .CROP_Y0(CY0), .CROP_W(CW), .CROP_H(CH)
  ) dut (
    .sys_clk(clk),
    .sys_rst_n(rst_n),
    .enable(en),
    .vif(vif),
    .h_disp(h_disp),
    .v_disp(v_disp),
    .res_valid(res_valid),
    .frame_cnt(frame_cnt),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    int          x;
    int          y;
    bit          f;
  } px_t;

  px_t exp_q[$];
  int  checks = 0, errors = 0;
  int  m_done = 0, mon_done = 0, m_cnt = 0;
  int  m_h = 0, m_v = 0, m_lines = 0, m_max = 0, m_npix = 0;
  bit  m_act = 0, m_en = 0, m_err = 0, m_res = 0, m_first = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rgb565(input logic [23:0] c);
    int r, g, b;
    r = int'(c) / 65536;
    g = (int'(c) / 256) % 256;
    b = int'(c) % 256;
    return 16'((r / 8) * 2048 + (g / 4) * 32 + b / 8);
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_px(input int i, input int yl, input logic [23:0] c);
    px_t e;
    int  x, y;
    x = (i < HM) ? i : HM - 1;
    y = (yl < VM) ? yl : VM - 1;
    if (i >= HM || yl >= VM) m_err = 1;
`ifdef RGB_RX_CROP_EN
    if (x < CX0 || x >= CX0 + CW || y < CY0 || y >= CY0 + CH) return;
    x -= CX0;
    y -= CY0;
`endif
    e.d = rgb565(c);
    e.x = x;
    e.y = y;
    e.f = m_first;
    m_first = 0;
    exp_q.push_back(e);
  endtask

  task automatic end_line(input int len);
    if (m_act) begin
      m_lines++;
      m_npix += len;
      if (len > m_max) m_max = len;
    end
  endtask

  task automatic line(input int len);
    int yl;
    yl = m_lines;
    for (int i = 0; i < len; i++) begin
      logic [23:0] c;
      c = 24'($urandom);
      vif.rx_de  = 1'b1;
      vif.rx_rgb = c;
      if (m_act) push_px(i, yl, c);
      tick();
    end
    vif.rx_de = 1'b0;
    vif.rx_hs = 1'b0;
    tick();
    vif.rx_hs = 1'b1;
    tick(2);
    end_line(len);
  endtask

  // A VS edge closes the running frame (if any) and may open the next one
  task automatic vs_pulse();
    if (m_act) begin
      m_done++;
      m_cnt = (m_cnt + 1) % 256;
      if (m_npix > 0) begin
        m_h   = (m_max < HM) ? m_max : HM;
        m_v   = (m_lines < VM) ? m_lines : VM;
        m_res = 1;
      end
      m_act = m_en;
    end else if (m_en) begin
      m_act = 1;
    end
    m_lines = 0;
    m_max   = 0;
    m_npix  = 0;
    m_first = 1;
    vif.rx_vs = 1'b0;
    tick(2);
    vif.rx_vs = 1'b1;
    tick(4);
  endtask

  task automatic set_en(input bit v);
    if (v && !m_en && !m_act) m_err = 0;
    m_en = v;
    en   = v;
    tick(3);
  endtask

  task automatic status(input string tag);
    chk({tag, "_hdisp"}, h_disp, m_h);
    chk({tag, "_vdisp"}, v_disp, m_v);
    chk({tag, "_resv"}, res_valid, m_res);
    chk({tag, "_fcnt"}, frame_cnt, m_cnt);
    chk({tag, "_err"}, err_ovf, m_err);
    chk({tag, "_done"}, mon_done, m_done);
    chk({tag, "_pend"}, exp_q.size(), 0);
  endtask

  task automatic zero_chk(input string tag);
    chk({tag, "_pv"}, vif.pix_valid, 0);
    chk({tag, "_pd"}, vif.pix_data, 0);
    chk({tag, "_xy"}, {vif.pix_xpos, vif.pix_ypos}, 0);
    chk({tag, "_fsfd"}, {vif.frame_start, vif.frame_done}, 0);
    chk({tag, "_disp"}, {h_disp, v_disp, res_valid}, 0);
    chk({tag, "_cnt"}, {frame_cnt, err_ovf}, 0);
  endtask

  task automatic mid_reset();
    rst_n = 1'b0;
    #2;
    zero_chk("midrst");
    m_act = 0; m_err = 0; m_cnt = 0;
    m_h = 0; m_v = 0; m_res = 0;
    m_lines = 0; m_max = 0; m_npix = 0;
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic lat_pixel();
    int yl;
    yl = m_lines;
    vif.rx_de  = 1'b1;
    vif.rx_rgb = 24'hFF8040;
    if (m_act) push_px(0, yl, 24'hFF8040);
    tick();
    vif.rx_de = 1'b0;
    chk("lat_early", vif.pix_valid, 0);
    tick();
    chk("lat_valid", vif.pix_valid, 1);
    chk("lat_data", vif.pix_data, 16'hFC08);
    tick(2);
    end_line(1);
  endtask

  always @(negedge clk) begin
    if (vif.frame_done) mon_done++;
    if (vif.frame_start && !vif.pix_valid) chk("fs_align", 1, 0);
    if (vif.pix_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexp_pix", vif.pix_valid, 0);
      end else begin
        px_t e;
        e = exp_q.pop_front();
        chk("pix_data", vif.pix_data, e.d);
        chk("pix_x", vif.pix_xpos, e.x);
        chk("pix_y", vif.pix_ypos, e.y);
        chk("pix_fs", vif.frame_start, e.f);
      end
    end
  end

  initial begin
    vif.rx_vs  = 1'b1;
    vif.rx_hs  = 1'b1;
    vif.rx_de  = 1'b0;
    vif.rx_rgb = '0;
    tick(2);
    zero_chk("reset");
    rst_n = 1'b1;
    tick(2);
    set_en(1);

    line(8);
    line(8);
    status("pre_vs");

    for (int f = 0; f < 3; f++) begin
      vs_pulse();
      repeat (4) line(8);
    end
    vs_pulse();
    status("f3");
    chk("f3_cnt", frame_cnt, 3);
    chk("f3_hdisp", h_disp, 8);
    chk("f3_vdisp", v_disp, 4);

    line(6);
    line(8);
    line(7);
    line(8);
    vs_pulse();
    status("mixlen");
    chk("mix_hdisp", h_disp, 8);
    chk("mix_vdisp", v_disp, 4);
    chk("mix_err", err_ovf, 0);

`ifndef RGB_RX_CROP_EN
    lat_pixel();
`endif
    line(5);
    vs_pulse();
    status("lat");
    vs_pulse();
    status("empty");

    repeat (6) begin
      int nl;
      nl = int'($urandom_range(0, 7));
      for (int l = 0; l < nl; l++) line(int'($urandom_range(1, 10)));
      vs_pulse();
      status("rnd");
    end

    line(10);
    line(3);
    vs_pulse();
    status("ovf");
    chk("ovf_set", err_ovf, 1);
    line(5);
    vs_pulse();
    chk("ovf_sticky", err_ovf, 1);

    line(4);
    line(4);
    set_en(0);
    line(4);
    vs_pulse();
    status("en_drop");
    line(6);
    line(6);
    vs_pulse();
    status("idle");

    set_en(1);
    chk("err_clear", err_ovf, 0);
    vs_pulse();
    line(8);
    line(8);
    mid_reset();
    status("after_rst");

    vs_pulse();
    repeat (3) line(7);
    vs_pulse();
    status("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
